syscall_unit: RTL and testbench

Responder for the `syscall_control` strobe produced by the instruction decoder. It services the MIPS console syscalls: print int, print string, print char and exit. The service code comes from `$v0` and the argument from `$a0`. It stalls the pipeline while busy, fetches string bytes through a word-wide memory read port, and streams ASCII characters to the console over a valid/ready interface.

---
 rtl/syscall_unit_pkg.sv | 41 ++++
 rtl/syscall_int2dec.sv | 53 +++++
 rtl/syscall_unit.sv | 185 ++++++++++++++++++
 tb/tb_syscall_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_unit_pkg.sv
// Shared definitions for the console syscall responder: service codes,
// FSM state encoding and small byte/ASCII helpers.
package syscall_unit_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  // A 32-bit magnitude has at most 10 decimal digits.
  localparam int unsigned DIGITS = 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INT_CONV,
    S_INT_EMIT,
    S_STR_REQ,
    S_STR_WAIT,
    S_STR_EMIT,
    S_CHAR_EMIT,
    S_FIN,
    S_HALTED
  } state_t;

  // Little-endian byte k of a word.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

endpackage

// File: rtl/syscall_int2dec.sv
// Binary-to-decimal digit generator for print-int.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   start, value    load |value| (unsigned 32-bit) and produce its first digit
//   busy            more digits still to be produced
//   count           number of digits in the buffer (least-significant at 0)
//   rd_idx/rd_digit read port into the digit buffer
module syscall_int2dec
  import syscall_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic [3:0]  count,
  input  logic [3:0]  rd_idx,
  output logic [3:0]  rd_digit
);

  logic [31:0] mag;
  logic [31:0] step_in;
  logic [3:0]  step_cnt;
  logic [3:0]  digits [DIGITS];

  // The start cycle already performs the first divide step so that the
  // conversion takes exactly one cycle per digit.
  always_comb begin
    step_in  = mag;
    step_cnt = count;
    if (start) begin
      step_in  = value[31] ? (~value + 32'd1) : value;
      step_cnt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag   <= '0;
      busy  <= 1'b0;
      count <= '0;
      for (int unsigned i = 0; i < DIGITS; i++) digits[i] <= '0;
    end else if (start || busy) begin
      digits[step_cnt] <= 4'(step_in % 32'd10);
      mag              <= step_in / 32'd10;
      count            <= step_cnt + 4'd1;
      busy             <= (step_in >= 32'd10);
    end
  end

  assign rd_digit = (rd_idx < 4'(DIGITS)) ? digits[rd_idx] : '0;

endmodule

// File: rtl/syscall_unit.sv
// Console syscall responder: print int (1), print string (4), exit (10),
// print char (11). Stalls the pipeline while servicing.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   syscall_control, v0, a0    strobe, service code, argument
//   stall                      hold PC/pipeline
//   mem_req/mem_addr/mem_ack/mem_rdata   word read port for string bytes
//   char_valid/char_data/char_ready      console character stream
//   done                       one-cycle service-complete pulse
//   halted, err                sticky exit / error flags
module syscall_unit
  import syscall_unit_pkg::*;
#(
  parameter int unsigned MAX_STR = 256,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              syscall_control,
  input  logic [31:0]       v0,
  input  logic [31:0]       a0,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              char_valid,
  output logic [7:0]        char_data,
  input  logic              char_ready,
  output logic              done,
  output logic              halted,
  output logic              err
);

  localparam int unsigned     CW   = $clog2(MAX_STR + 1);
  localparam logic [CW-1:0]   LAST = CW'(MAX_STR - 1);

  state_t            state;
  logic              neg;
  logic [ADDR_W-1:0] ptr;
  logic [31:0]       word;
  logic [CW-1:0]     str_cnt;
  logic [3:0]        emit_idx;
  logic              conv_start;
  logic              conv_busy;
  logic [3:0]        conv_count;
  logic [3:0]        rd_idx;
  logic [3:0]        rd_digit;
  logic [7:0]        next_byte;

  assign conv_start = (state == S_IDLE) && syscall_control && (v0 == SYS_PRINT_INT);
  assign stall      = (state != S_IDLE) || syscall_control;
  // emit_idx counts digits still to send; the next one lives at emit_idx-1.
  assign rd_idx     = (state == S_INT_CONV) ? conv_count - 4'd1 : emit_idx - 4'd1;
  assign next_byte  = byte_sel(word, ptr[1:0] + 2'd1);

  syscall_int2dec u_int2dec (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (conv_start),
    .value    (a0),
    .busy     (conv_busy),
    .count    (conv_count),
    .rd_idx   (rd_idx),
    .rd_digit (rd_digit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      neg        <= 1'b0;
      ptr        <= '0;
      word       <= '0;
      str_cnt    <= '0;
      emit_idx   <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      char_valid <= 1'b0;
      char_data  <= '0;
      done       <= 1'b0;
      halted     <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: if (syscall_control) begin
          case (v0)
            SYS_PRINT_INT: begin
              neg   <= a0[31];
              state <= S_INT_CONV;
            end
            SYS_PRINT_STR: begin
              ptr     <= ADDR_W'(a0);
              str_cnt <= '0;
              state   <= S_STR_REQ;
            end
            SYS_PRINT_CHAR: begin
              char_valid <= 1'b1;
              char_data  <= a0[7:0];
              state      <= S_CHAR_EMIT;
            end
            SYS_EXIT: begin
              halted <= 1'b1;
              done   <= 1'b1;
              state  <= S_HALTED;
            end
            default: begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= S_FIN;
            end
          endcase
        end
        S_INT_CONV: if (!conv_busy) begin
          char_valid <= 1'b1;
          state      <= S_INT_EMIT;
          if (neg) begin
            char_data <= 8'h2D;
            emit_idx  <= conv_count;
          end else begin
            char_data <= ascii_digit(rd_digit);
            emit_idx  <= conv_count - 4'd1;
          end
        end
        S_INT_EMIT: if (char_ready) begin
          if (emit_idx == 4'd0) begin
            char_valid <= 1'b0;
            done       <= 1'b1;
            state      <= S_FIN;
          end else begin
            char_data <= ascii_digit(rd_digit);
            emit_idx  <= emit_idx - 4'd1;
          end
        end
        S_STR_REQ: begin
          mem_req  <= 1'b1;
          mem_addr <= {ptr[ADDR_W-1:2], 2'b00};
          state    <= S_STR_WAIT;
        end
        // The fetched byte is inspected straight off the read bus so the
        // first character of a word is presented on the cycle after ack.
        S_STR_WAIT: if (mem_ack) begin
          mem_req <= 1'b0;
          word    <= mem_rdata;
          if (byte_sel(mem_rdata, ptr[1:0]) == 8'h00) begin
            done  <= 1'b1;
            state <= S_FIN;
          end else begin
            char_valid <= 1'b1;
            char_data  <= byte_sel(mem_rdata, ptr[1:0]);
            state      <= S_STR_EMIT;
          end
        end
        S_STR_EMIT: if (char_ready) begin
          ptr     <= ptr + ADDR_W'(1);
          str_cnt <= str_cnt + CW'(1);
          if (str_cnt == LAST) begin
            err        <= 1'b1;
            char_valid <= 1'b0;
            done       <= 1'b1;
            state      <= S_FIN;
          end else if (ptr[1:0] == 2'd3) begin
            char_valid <= 1'b0;
            state      <= S_STR_REQ;
          end else if (next_byte == 8'h00) begin
            char_valid <= 1'b0;
            done       <= 1'b1;
            state      <= S_FIN;
          end else begin
            char_data <= next_byte;
          end
        end
        S_CHAR_EMIT: if (char_ready) begin
          char_valid <= 1'b0;
          done       <= 1'b1;
          state      <= S_FIN;
        end
        S_FIN:    state <= S_IDLE;
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_unit.sv
module tb_syscall_unit;

  localparam int unsigned MAX_STR = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        syscall_control = 1'b0;
  logic [31:0] v0 = '0;
  logic [31:0] a0 = '0;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        char_ready = 1'b1;
  logic        done;
  logic        halted;
  logic        err;

  always #5 clk = ~clk;

  syscall_unit #(.MAX_STR(MAX_STR), .ADDR_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .syscall_control (syscall_control),
    .v0              (v0),
    .a0              (a0),
    .stall           (stall),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .char_valid      (char_valid),
    .char_data       (char_data),
    .char_ready      (char_ready),
    .done            (done),
    .halted          (halted),
    .err             (err)
  );

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] addr_q[$];
  int          mem_lat = 0;
  bit          mem_mode = 1'b0;
  bit          rdy_rand = 1'b0;
  int          wait_cnt = 0;
  bit          pend = 1'b0;
  logic [7:0]  pdata = '0;

  typedef struct {
    logic [31:0] code;
    logic [31:0] arg;
    string       text;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Word memory: fixed "Hello!" image, or a region with no zero bytes.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (mem_mode) return {addr[7:0] | 8'h80, 8'h52, 8'h55, 8'h4E};
    case (addr)
      32'h100: return 32'h6C654855;
      32'h104: return 32'h00216F6C;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Memory responder: ack after mem_lat extra cycles, log each address.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wait_cnt = 0;
        mem_ack  = 1'b0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (wait_cnt >= mem_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          addr_q.push_back(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Console ready driver.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      char_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Scoreboard consumer and data-stability monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
      end else if (char_valid) begin
        if (pend) chk("char_stable", char_data, pdata);
        if (char_ready) begin
          chk("char_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("char_data", char_data, exp_q.pop_front());
        end
        pend  = !char_ready;
        pdata = char_data;
      end else begin
        pend = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic push_text(input string s);
    for (int j = 0; j < s.len(); j++) exp_q.push_back(8'(s[j]));
  endtask

  task automatic strobe(input logic [31:0] code, input logic [31:0] arg);
    @(posedge clk);
    #1;
    syscall_control = 1'b1;
    v0 = code;
    a0 = arg;
    #1;
    chk("stall_on_strobe", stall, 1);
    @(posedge clk);
    #1;
    syscall_control = 1'b0;
  endtask

  task automatic run_service(input string tag, input logic [31:0] code, input logic [31:0] arg,
                             input int budget, input bit stall_after,
                             output int first_char, output int first_done);
    int k;
    k = 0;
    first_char = -1;
    first_done = -1;
    strobe(code, arg);
    while (first_done < 0 && k < budget) begin
      @(negedge clk);
      k++;
      if (first_char < 0 && char_valid) first_char = k;
      if (done) first_done = k;
    end
    chk({tag, "_done_seen"}, first_done > 0, 1);
    @(negedge clk);
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_stall_after"}, stall, stall_after);
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    int fc, fd, cnt_a, cnt_b;
    logic [31:0] aa, w;

    vecs[0] = '{32'd1,  32'hFFFF_FECF, "-305",        4};
    vecs[1] = '{32'd1,  32'h0000_0000, "0",           2};
    vecs[2] = '{32'd1,  32'h8000_0000, "-2147483648", 11};
    vecs[3] = '{32'd1,  32'h7FFF_FFFF, "2147483647",  11};
    vecs[4] = '{32'd1,  32'h0000_0007, "7",           2};
    vecs[5] = '{32'd11, 32'h0000_015A, "Z",           1};

    #12;
    chk("reset_outputs", {stall, mem_req, mem_addr, char_valid, char_data, done, halted, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      rdy_rand = (i % 2) == 1;
      push_text(vecs[i].text);
      run_service($sformatf("vec%0d", i), vecs[i].code, vecs[i].arg, 200, 1'b0, fc, fd);
      chk($sformatf("vec%0d_latency", i), fc, vecs[i].lat);
    end

    // Print char passes NUL through.
    rdy_rand = 1'b0;
    exp_q.push_back(8'h00);
    run_service("char_nul", 32'd11, 32'h1234_5600, 50, 1'b0, fc, fd);
    chk("char_nul_latency", fc, 1);

    // Unaligned string starting at byte 1 of word 0x100, random ready.
    mem_mode = 1'b0;
    mem_lat  = 2;
    rdy_rand = 1'b1;
    addr_q.delete();
    push_text("Hello!");
    run_service("hello", 32'd4, 32'h0000_0101, 300, 1'b0, fc, fd);
    chk("hello_latency", fc, 3 + mem_lat);
    chk("hello_req_count", addr_q.size(), 2);
    if (addr_q.size() == 2) begin
      chk("hello_addr0", addr_q[0], 32'h100);
      chk("hello_addr1", addr_q[1], 32'h104);
    end
    chk("hello_err", err, 0);

    // Runaway string: stops after MAX_STR characters with err set.
    mem_mode = 1'b1;
    mem_lat  = 0;
    rdy_rand = 1'b0;
    addr_q.delete();
    for (int i = 0; i < MAX_STR; i++) begin
      aa = 32'h200 + 32'(i);
      w  = mem_word({aa[31:2], 2'b00});
      exp_q.push_back(8'(w >> {aa[1:0], 3'b000}));
    end
    run_service("runaway", 32'd4, 32'h0000_0200, 3000, 1'b0, fc, fd);
    chk("runaway_err", err, 1);
    chk("runaway_fetches", addr_q.size(), MAX_STR / 4);

    // Reset while waiting for memory.
    mem_mode = 1'b0;
    mem_lat  = 20;
    strobe(32'd4, 32'h0000_0100);
    repeat (4) @(negedge clk);
    chk("rst_precond_req", mem_req, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {stall, mem_req, mem_addr, char_valid, char_data, done, halted, err}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    mem_lat = 0;
    exp_q.push_back(8'h41);
    run_service("after_reset", 32'd11, 32'h0000_0041, 50, 1'b0, fc, fd);
    chk("after_reset_latency", fc, 1);
    chk("after_reset_err", err, 0);

    // Unknown code.
    run_service("unknown", 32'd7, 32'h0000_0041, 20, 1'b0, fc, fd);
    chk("unknown_done_latency", fd, 1);
    chk("unknown_no_char", fc, -1);
    chk("unknown_err", err, 1);

    // Exit: sticky halt, further strobes ignored.
    run_service("exit", 32'd10, 32'h0, 20, 1'b1, fc, fd);
    chk("exit_done_latency", fd, 1);
    chk("exit_halted", halted, 1);
    cnt_a = 0;
    repeat (50) begin
      @(negedge clk);
      if (!stall) cnt_a++;
    end
    chk("exit_stall_held", cnt_a, 0);
    strobe(32'd11, 32'h0000_0051);
    cnt_a = 0;
    cnt_b = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) cnt_a++;
      if (char_valid) cnt_b++;
    end
    chk("halted_no_done", cnt_a, 0);
    chk("halted_no_char", cnt_b, 0);
    chk("halted_sticky", {halted, stall}, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
